seg7_scan_driver: RTL and testbench

Downstream consumer of the number-to-ASCII converter: accepts per-digit ASCII write strobes (`commit`, `an_sel`, `ascii_lut_addr`), translates each code to a 7-segment pattern through a registered character ROM, stores it in an 8-entry digit buffer, and time-multiplexes the buffer onto the board's common-anode 8-digit display. It is the last stage before the display pins.

---
 rtl/seg7_scan_driver_pkg.sv | 47 ++++
 rtl/seg7_scan_driver_ascii_seg_rom.sv | 30 +++
 rtl/seg7_scan_driver.sv | 111 +++++++++++
 tb/tb_seg7_scan_driver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: segment bit positions,
// active-low glyph constants and the slot-length helper.
package seg7_scan_driver_pkg;

  localparam int unsigned SegA  = 0;
  localparam int unsigned SegB  = 1;
  localparam int unsigned SegC  = 2;
  localparam int unsigned SegD  = 3;
  localparam int unsigned SegE  = 4;
  localparam int unsigned SegF  = 5;
  localparam int unsigned SegG  = 6;
  localparam int unsigned SegDp = 7;

  localparam logic [7:0] GlyphBlank = 8'hFF;
  localparam logic [7:0] GlyphDash  = ~(8'h01 << SegG);
  localparam logic [7:0] GlyphUnder = ~(8'h01 << SegD);

  // Hex glyphs 0..F, active-low, dp off.
  localparam logic [7:0] GlyphHex [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic int unsigned calc_div(int unsigned sysclk_f, int unsigned refresh_hz,
                                           int unsigned digits);
    return sysclk_f / (refresh_hz * digits);
  endfunction

  // Maps an ASCII code to its segment pattern; unknown codes are blank.
  function automatic logic [7:0] ascii_glyph(int unsigned code);
    logic [7:0] g;
    g = GlyphBlank;
    if (code >= 48 && code <= 57) begin
      g = GlyphHex[4'(code - 48)];
    end else if (code >= 65 && code <= 70) begin
      g = GlyphHex[4'(code - 55)];
    end else if (code >= 97 && code <= 102) begin
      g = GlyphHex[4'(code - 87)];
    end else if (code == 45) begin
      g = GlyphDash;
    end else if (code == 95) begin
      g = GlyphUnder;
    end
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_ascii_seg_rom.sv
// Synchronous-read character ROM: ASCII code in, active-low segment pattern
// out one cycle later.
module ascii_seg_rom
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] addr_i,
  output logic [7:0]       data_o
);

  logic [7:0] rom [Depth];
  logic [7:0] data_q;

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      rom[i] = ascii_glyph(i);
    end
  end

  // No reset on the read register so the ROM maps onto block RAM.
  always_ff @(posedge clk_i) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Common-anode 8-digit display driver: ASCII writes go through a character
// ROM into a digit buffer that is time-multiplexed onto the anodes.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned SYSCLK_F       = 24000000,
  parameter int unsigned REFRESH_HZ     = 1000,
  parameter int unsigned CAN_CT         = 8,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned ASCII_LUT_SIZE = 256
) (
  input  logic                              sys_clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              commit,
  input  logic [$clog2(CAN_CT)-1:0]         an_sel,
  input  logic [$clog2(ASCII_LUT_SIZE)-1:0] ascii_lut_addr,
  output logic [7:0]                        seg,
  output logic [CAN_CT-1:0]                 an
);

  localparam int unsigned IdxW  = $clog2(CAN_CT);
  localparam int unsigned Div   = calc_div(SYSCLK_F, REFRESH_HZ, CAN_CT);
  localparam int unsigned SlotW = $clog2(Div);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(Div - 1);
  localparam logic [SlotW-1:0] BlankEnd = SlotW'(BLANK_CYCLES);

  if (Div < BLANK_CYCLES + 2) begin : g_bad_div
    $error("seg7_scan_driver: slot length too short for the blank window");
  end
  if ((CAN_CT < 2) || ((CAN_CT & (CAN_CT - 1)) != 0)) begin : g_bad_can_ct
    $error("seg7_scan_driver: CAN_CT must be a power of two");
  end

  logic            wr_vld_q, wr_vld_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]      rom_data;
  logic [7:0]      buf_q [CAN_CT];
  logic [7:0]      buf_d [CAN_CT];

  logic [SlotW-1:0]  slot_q, slot_d;
  logic [IdxW-1:0]   scan_q, scan_d;
  logic [CAN_CT-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  ascii_seg_rom #(
    .Depth(ASCII_LUT_SIZE)
  ) u_rom (
    .clk_i (sys_clk),
    .addr_i(ascii_lut_addr),
    .data_o(rom_data)
  );

  // Stage 1 captures the index alongside the ROM read; stage 2 lands the
  // glyph regardless of en so an accepted write is never dropped.
  always_comb begin
    wr_vld_d = commit & en & (32'(an_sel) < CAN_CT);
    wr_idx_d = an_sel;
    buf_d    = buf_q;
    if (wr_vld_q) begin
      buf_d[wr_idx_q] = rom_data;
    end
  end

  always_comb begin
    slot_d = slot_q;
    scan_d = scan_q;
    if (en) begin
      if (slot_q == SlotLast) begin
        slot_d = '0;
        scan_d = scan_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Anodes follow the next-state counters so they blank on the same edge the
  // scan index moves; seg follows the current index and lags by one cycle.
  always_comb begin
    an_d = '1;
    if (en && (slot_d >= BlankEnd)) begin
      an_d[scan_d] = 1'b0;
    end
    seg_d = buf_q[scan_q];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_q <= 1'b0;
      wr_idx_q <= '0;
      buf_q    <= '{default: GlyphBlank};
      slot_q   <= '0;
      scan_q   <= '0;
      an_q     <= '1;
      seg_q    <= GlyphBlank;
    end else begin
      wr_vld_q <= wr_vld_d;
      wr_idx_q <= wr_idx_d;
      buf_q    <= buf_d;
      slot_q   <= slot_d;
      scan_q   <= scan_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame-position reference
// model, plus directed literal checks of glyphs and timing.
module tb_seg7_scan_driver;

  localparam int unsigned SysclkF     = 2400000;
  localparam int unsigned RefreshHz   = 1000;
  localparam int unsigned CanCt       = 8;
  localparam int unsigned BlankCycles = 16;
  localparam int unsigned LutSize     = 256;
  localparam int Div   = SysclkF / (RefreshHz * CanCt);
  localparam int Frame = Div * CanCt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       commit = 1'b0;
  logic [2:0] an_sel = '0;
  logic [7:0] addr = '0;
  logic [7:0] seg;
  logic [7:0] an;

  int total = 0;
  int bad = 0;

  string hex_segs [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  seg7_scan_driver #(
    .SYSCLK_F      (SysclkF),
    .REFRESH_HZ    (RefreshHz),
    .CAN_CT        (CanCt),
    .BLANK_CYCLES  (BlankCycles),
    .ASCII_LUT_SIZE(LutSize)
  ) dut (
    .sys_clk       (clk),
    .rst_n         (rst_n),
    .en            (en),
    .commit        (commit),
    .an_sel        (an_sel),
    .ascii_lut_addr(addr),
    .seg           (seg),
    .an            (an)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] segs_to_byte(string s);
    logic [7:0] b;
    b = 8'hFF;
    for (int i = 0; i < s.len(); i++) begin
      b[int'(s[i]) - 97] = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [7:0] ref_glyph(int c);
    int v;
    v = -1;
    if (c >= 48 && c <= 57) v = c - 48;        // '0'..'9'
    else if (c >= 65 && c <= 70) v = c - 55;   // 'A'..'F'
    else if (c >= 97 && c <= 102) v = c - 87;  // 'a'..'f'
    if (v >= 0) return segs_to_byte(hex_segs[v]);
    if (c == 45) return segs_to_byte("g");     // '-'
    if (c == 95) return segs_to_byte("d");     // '_'
    return 8'hFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Model: position in the frame counts enabled edges; outputs are derived
  // from that position and a buffer that takes each write one edge late.
  initial begin : model
    int         t;
    logic [7:0] mbuf [8];
    bit         pv;
    int         pidx;
    logic [7:0] pval;
    bit         fresh;
    logic [7:0] eseg;
    logic [7:0] ean;
    t = 0; pv = 0; pidx = 0; pval = 8'hFF; fresh = 1; eseg = 8'hFF; ean = 8'hFF;
    for (int i = 0; i < 8; i++) mbuf[i] = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_seg", seg, 8'hFF);
        check("rst_an", an, 8'hFF);
        t = 0; pv = 0; fresh = 1;
        for (int i = 0; i < 8; i++) mbuf[i] = 8'hFF;
      end else begin
        if (fresh) begin
          eseg = 8'hFF;
          ean = 8'hFF;
          fresh = 0;
        end
        check("seg", seg, eseg);
        check("an", an, ean);
        eseg = mbuf[(t / Div) % CanCt];
        if (pv) mbuf[pidx] = pval;
        pv = commit && en;
        pidx = int'(an_sel);
        pval = ref_glyph(int'(addr));
        if (en) t = (t + 1) % Frame;
        ean = (en && (t % Div) >= BlankCycles) ? ~(8'h01 << (t / Div)) : 8'hFF;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input int code);
    commit = 1'b1;
    an_sel = 3'(idx);
    addr = 8'(code);
    tick();
  endtask

  // Waits for the edge on which digit d becomes lit.
  task automatic wait_lit(input int d, input int limit);
    logic [7:0] tgt;
    logic [7:0] prev;
    bit ok;
    tgt = ~(8'h01 << d);
    prev = an;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (an == tgt && prev != tgt) ok = 1;
      prev = an;
    end
    if (!ok) check("wait_lit_timeout", an, tgt);
  endtask

  initial begin : stim
    int n1;
    int n2;
    repeat (3) tick();
    check("reset_seg_lit", seg, 8'hFF);
    check("reset_an_lit", an, 8'hFF);
    rst_n = 1'b1;
    en = 1'b1;

    wait_lit(0, 1000);
    n1 = 0;
    while (an != 8'hFF && n1 < 1000) begin tick(); n1++; end
    n2 = 0;
    while (an != 8'hFD && n2 < 1000) begin tick(); n2++; end
    check("blank_len", n2, 16);
    check("slot_len", n1 + n2, 300);
    repeat (2 * Frame) tick();

    put(3, 8'h30); put(4, 8'h31); put(5, 8'h38);
    put(0, 8'h7A); put(1, 8'h2D);
    commit = 1'b0;
    wait_lit(3, 2 * Frame); check("digit3_zero", seg, 8'hC0);
    wait_lit(4, 2 * Frame); check("digit4_one", seg, 8'hF9);
    wait_lit(5, 2 * Frame); check("digit5_eight", seg, 8'h80);
    wait_lit(0, 2 * Frame); check("digit0_z", seg, 8'hFF);
    wait_lit(1, 2 * Frame); check("digit1_dash", seg, 8'hBF);

    wait_lit(2, 2 * Frame);
    repeat (50) tick();
    en = 1'b0;
    tick();
    check("en_low_an", an, 8'hFF);
    repeat (99) tick();
    put(2, 8'h35);
    commit = 1'b0;
    repeat (399) tick();
    en = 1'b1;
    tick();
    check("resume_an", an, 8'hFB);
    check("resume_seg_blank", seg, 8'hFF);
    n1 = 1;
    while (an != 8'hFF && n1 < 1000) begin tick(); n1++; end
    check("resume_remaining", n1, 234);

    wait_lit(6, 2 * Frame);
    repeat (20) tick();
    put(6, 8'h41);
    commit = 1'b0;
    check("lit_edge_n", seg, 8'hFF);
    tick();
    check("lit_edge_n1", seg, 8'hFF);
    tick();
    check("lit_edge_n2", seg, 8'h88);

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      commit = ($urandom_range(0, 2) == 0);
      an_sel = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(45, 102))
                                         : 8'($urandom_range(0, 255));
      tick();
    end
    commit = 1'b0;
    en = 1'b1;
    repeat (Frame) tick();

    put(5, 8'h38);
    commit = 1'b0;
    wait_lit(5, 2 * Frame);
    check("pre_reset_seg", seg, 8'h80);
    repeat (20) tick();
    put(5, 8'h31);
    commit = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_an", an, 8'hFF);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_lit(5, 2 * Frame); check("post_reset_d5", seg, 8'hFF);
    wait_lit(3, 2 * Frame); check("post_reset_d3", seg, 8'hFF);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
